// File: rtl/windowed_register_file_pkg.sv
// Shared constants and helpers for the windowed register file.
// Defines the logical-to-physical mapping and wrap-around CWP arithmetic.
package windowed_register_file_pkg;

  localparam int GLOBAL_BASE = 0;
  localparam int OUT_BASE    = 8;
  localparam int LOCAL_BASE  = 16;
  localparam int IN_BASE     = 24;

  localparam int GLOBALS     = 8;
  localparam int WIN_WORDS   = 16;

  function automatic int cwp_inc(input int cur, input int nwin);
    return (cur == nwin - 1) ? 0 : cur + 1;
  endfunction

  function automatic int cwp_dec(input int cur, input int nwin);
    return (cur == 0) ? nwin - 1 : cur - 1;
  endfunction

  // Outs and locals of one window are contiguous, so r8..r23 map linearly;
  // the ins of window w are the outs of window w+1.
  function automatic int phys_index(input logic [4:0] addr, input int cur, input int nwin);
    int a;
    a = int'(addr);
    if (a < OUT_BASE)
      return a - GLOBAL_BASE;
    else if (a < IN_BASE)
      return GLOBALS + WIN_WORDS * cur + (a - OUT_BASE);
    else
      return GLOBALS + WIN_WORDS * cwp_inc(cur, nwin) + (a - IN_BASE);
  endfunction

  function automatic bit is_local(input logic [4:0] addr);
    return (int'(addr) >= LOCAL_BASE) && (int'(addr) < IN_BASE);
  endfunction

endpackage

// File: rtl/windowed_register_file_window_addr_map.sv
// Logical register number plus CWP to physical word index.
// Purely combinational; no flow control.
module window_addr_map
  import windowed_register_file_pkg::*;
#(
  parameter int NWINDOWS = 8,
  parameter int CWPW     = 5,
  parameter int PW       = 8
) (
  input  logic [4:0]      addr,
  input  logic [CWPW-1:0] cwp,
  output logic [PW-1:0]   pidx
);

  assign pidx = PW'(phys_index(addr, int'(cwp), NWINDOWS));

endmodule

// File: rtl/windowed_register_file.sv
// SPARC-style windowed register file: 2 combinational reads, 1 write, CWP shift/load.
// Writes and CWP changes land at the next Clk edge; no backpressure, traps are one-cycle pulses.
module windowed_register_file
  import windowed_register_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8,
  parameter int CWPW     = 5
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [4:0]          ra_addr,
  input  logic [4:0]          rb_addr,
  output logic [WIDTH-1:0]    ra_data,
  output logic [WIDTH-1:0]    rb_data,
  input  logic [4:0]          wc_addr,
  input  logic [WIDTH-1:0]    wc_data,
  input  logic                wc_en,
  input  logic                save,
  input  logic                restore,
  input  logic                cwp_ld,
  input  logic [CWPW-1:0]     cwp_in,
  input  logic [NWINDOWS-1:0] wim,
  output logic [CWPW-1:0]     cwp,
  output logic                ovf_trap,
  output logic                unf_trap,
  output logic                illegal_op
);

  localparam int NWORDS = GLOBALS + WIN_WORDS * NWINDOWS;
  localparam int PW     = $clog2(NWORDS);

  logic [WIDTH-1:0]    mem [NWORDS];
  logic [CWPW-1:0]     cwp_q, cwp_d, cwp_dn, cwp_up;
  logic [PW-1:0]       pa, pb, pc;
  logic                wim_dn, wim_up;
  logic                ovf_d, unf_d, ill_d;

  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_map_a (
    .addr(ra_addr), .cwp(cwp_q), .pidx(pa)
  );
  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_map_b (
    .addr(rb_addr), .cwp(cwp_q), .pidx(pb)
  );
  window_addr_map #(.NWINDOWS(NWINDOWS), .CWPW(CWPW), .PW(PW)) u_map_c (
    .addr(wc_addr), .cwp(cwp_q), .pidx(pc)
  );

  // r0 is forced to zero on read; its physical word is never written.
  assign ra_data = (ra_addr == 5'd0) ? '0 : mem[pa];
  assign rb_data = (rb_addr == 5'd0) ? '0 : mem[pb];
  assign cwp     = cwp_q;

  assign cwp_dn = CWPW'(cwp_dec(int'(cwp_q), NWINDOWS));
  assign cwp_up = CWPW'(cwp_inc(int'(cwp_q), NWINDOWS));
  assign wim_dn = |(wim & (NWINDOWS'(1) << cwp_dn));
  assign wim_up = |(wim & (NWINDOWS'(1) << cwp_up));

  always_comb begin
    cwp_d = cwp_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    ill_d = 1'b0;
    if (cwp_ld) begin
      if (int'(cwp_in) < NWINDOWS) cwp_d = cwp_in;
      else                         ill_d = 1'b1;
    end else if (save && restore) begin
      ill_d = 1'b1;
    end else if (save) begin
      if (wim_dn) ovf_d = 1'b1;
      else        cwp_d = cwp_dn;
    end else if (restore) begin
      if (wim_up) unf_d = 1'b1;
      else        cwp_d = cwp_up;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      cwp_q      <= '0;
      ovf_trap   <= 1'b0;
      unf_trap   <= 1'b0;
      illegal_op <= 1'b0;
      for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
    end else begin
      cwp_q      <= cwp_d;
      ovf_trap   <= ovf_d;
      unf_trap   <= unf_d;
      illegal_op <= ill_d;
      if (wc_en && (wc_addr != 5'd0)) mem[pc] <= wc_data;
    end
  end

endmodule

// File: tb/tb_windowed_register_file.sv
// Randomized scoreboard bench for windowed_register_file against a per-window array model.
module tb_windowed_register_file;

  localparam int W  = 32;
  localparam int NW = 8;
  localparam int CW = 5;

  logic          Clk = 1'b0;
  logic          Clr;
  logic [4:0]    ra_addr, rb_addr, wc_addr;
  logic [W-1:0]  ra_data, rb_data, wc_data;
  logic          wc_en, save, restore, cwp_ld;
  logic [CW-1:0] cwp_in, cwp;
  logic [NW-1:0] wim;
  logic          ovf_trap, unf_trap, illegal_op;

  always #5 Clk = ~Clk;

  windowed_register_file #(.WIDTH(W), .NWINDOWS(NW), .CWPW(CW)) dut (
    .Clk(Clk), .Clr(Clr),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .wc_addr(wc_addr), .wc_data(wc_data), .wc_en(wc_en),
    .save(save), .restore(restore), .cwp_ld(cwp_ld), .cwp_in(cwp_in), .wim(wim),
    .cwp(cwp), .ovf_trap(ovf_trap), .unf_trap(unf_trap), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [W-1:0]  ra, rb;
    logic [CW-1:0] cwp;
    logic          ovf, unf, ill;
  } exp_t;

  typedef struct {
    logic          clr, we, sv, rs, ld;
    logic [4:0]    ra, rb, wa;
    logic [W-1:0]  wd;
    logic [CW-1:0] cin;
    logic [NW-1:0] wim;
  } stim_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: globals, and per-window outs/locals; ins alias the next window's outs.
  logic [W-1:0] m_glob [8];
  logic [W-1:0] m_outs [NW][8];
  logic [W-1:0] m_locs [NW][8];
  int m_cwp;
  bit m_ovf, m_unf, m_ill;
  bit known = 0;

  function automatic logic [W-1:0] mread(input logic [4:0] a);
    int r;
    r = int'(a);
    if (r == 0)      return '0;
    else if (r < 8)  return m_glob[r];
    else if (r < 16) return m_outs[m_cwp][r-8];
    else if (r < 24) return m_locs[m_cwp][r-16];
    else             return m_outs[(m_cwp + 1) % NW][r-24];
  endfunction

  task automatic mwrite(input logic [4:0] a, input logic [W-1:0] d);
    int r;
    r = int'(a);
    if (r == 0)      ;
    else if (r < 8)  m_glob[r] = d;
    else if (r < 16) m_outs[m_cwp][r-8] = d;
    else if (r < 24) m_locs[m_cwp][r-16] = d;
    else             m_outs[(m_cwp + 1) % NW][r-24] = d;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.clr = 0; s.we = 0; s.sv = 0; s.rs = 0; s.ld = 0;
    s.ra  = 5'($urandom_range(0, 31));
    s.rb  = 5'($urandom_range(0, 31));
    s.wa  = 5'($urandom_range(0, 31));
    s.wd  = $urandom;
    s.cin = '0;
    s.wim = '0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    int tgt;
    Clr = s.clr; wc_en = s.we; save = s.sv; restore = s.rs; cwp_ld = s.ld;
    ra_addr = s.ra; rb_addr = s.rb; wc_addr = s.wa; wc_data = s.wd;
    cwp_in = s.cin; wim = s.wim;
    if (known) begin
      e.ra = mread(s.ra); e.rb = mread(s.rb); e.cwp = CW'(m_cwp);
      e.ovf = m_ovf; e.unf = m_unf; e.ill = m_ill;
      q.push_back(e);
    end
    if (s.clr) begin
      for (int i = 0; i < 8; i++) m_glob[i] = '0;
      for (int w = 0; w < NW; w++)
        for (int i = 0; i < 8; i++) begin
          m_outs[w][i] = '0;
          m_locs[w][i] = '0;
        end
      m_cwp = 0; m_ovf = 0; m_unf = 0; m_ill = 0;
      known = 1;
    end else begin
      if (s.we) mwrite(s.wa, s.wd);
      m_ovf = 0; m_unf = 0; m_ill = 0;
      if (s.ld) begin
        if (int'(s.cin) < NW) m_cwp = int'(s.cin);
        else                  m_ill = 1;
      end else if (s.sv && s.rs) begin
        m_ill = 1;
      end else if (s.sv) begin
        tgt = (m_cwp + NW - 1) % NW;
        if (s.wim[3'(tgt)]) m_ovf = 1;
        else                m_cwp = tgt;
      end else if (s.rs) begin
        tgt = (m_cwp + 1) % NW;
        if (s.wim[3'(tgt)]) m_unf = 1;
        else                m_cwp = tgt;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle while the stimulus is stable.
  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ra_data", ra_data, e.ra);
      chk("rb_data", rb_data, e.rb);
      chk("cwp", W'(cwp), W'(e.cwp));
      chk("ovf_trap", W'(ovf_trap), W'(e.ovf));
      chk("unf_trap", W'(unf_trap), W'(e.unf));
      chk("illegal_op", W'(illegal_op), W'(e.ill));
    end
  end

  initial begin
    stim_t s;
    int p;
    Clr = 1; wc_en = 0; save = 0; restore = 0; cwp_ld = 0;
    ra_addr = 0; rb_addr = 0; wc_addr = 0; wc_data = 0; cwp_in = 0; wim = 0;
    @(posedge Clk);
    #1;

    s = idle(); s.clr = 1; step(s);
    // Same-cycle read sees old value, next cycle sees the write.
    s = idle(); s.we = 1; s.wa = 17; s.wd = 32'hDEADBEEF; s.ra = 17; step(s);
    s = idle(); s.ra = 17; s.rb = 17; step(s);

    s = idle(); s.ld = 1; s.cin = 3; step(s);
    s = idle(); s.we = 1; s.wa = 9; s.wd = 32'h11; step(s);
    s = idle(); s.sv = 1; s.ra = 9; step(s);
    s = idle(); s.ra = 25; s.we = 1; s.wa = 0; s.wd = 32'hFF; step(s);
    s = idle(); s.ra = 0; s.rb = 25; step(s);

    s = idle(); s.ld = 1; s.cin = 0; step(s);
    s = idle(); s.sv = 1; step(s);
    s = idle(); s.wim = 8'h40; s.sv = 1; step(s);
    s = idle(); step(s);
    s = idle(); s.wim = 8'h01; s.rs = 1; step(s);
    s = idle(); s.sv = 1; s.rs = 1; step(s);
    s = idle(); step(s);

    s = idle(); s.ld = 1; s.cin = 9; step(s);
    s = idle(); s.ld = 1; s.cin = 5; s.sv = 1; step(s);
    s = idle(); step(s);

    s = idle(); s.ld = 1; s.cin = 0; step(s);
    for (int r = 1; r < 8; r++) begin
      s = idle(); s.we = 1; s.wa = 5'(r); step(s);
    end
    for (int w = 0; w < NW; w++) begin
      s = idle(); s.ld = 1; s.cin = CW'(w); step(s);
      for (int r = 1; r < 8; r++) begin
        s = idle(); s.ra = 5'(r); s.rb = 5'(8 - r); step(s);
      end
    end

    s = idle(); s.clr = 1; s.sv = 1; s.we = 1; s.wa = 5; step(s);
    for (int r = 0; r < 32; r++) begin
      s = idle(); s.ra = 5'(r); s.rb = 5'(31 - r); step(s);
    end

    for (int n = 0; n < 3000; n++) begin
      s = idle();
      p = int'($urandom_range(0, 99));
      s.clr = (p < 2);
      s.ld  = (p >= 2 && p < 8);
      s.cin = CW'($urandom_range(0, 31));
      s.we  = ($urandom_range(0, 1) == 1);
      s.sv  = ($urandom_range(0, 3) == 0);
      s.rs  = ($urandom_range(0, 3) == 0);
      s.wim = NW'($urandom & $urandom);
      step(s);
    end
    s = idle(); step(s);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
